pe_nic: RTL and testbench
=========================

Name: pe_nic

Overview:
- Network interface controller between one processing element (PE) and the PE port of one mesh4x4 router.
- Drives the router's PE-input side: pesi (send), pedi (data), and samples pero (router ready).
- Accepts from the router's PE-output side: peso (send), pedo (data), and drives peri (NIC ready).
- The PE side sees a 2-bit register map with a single-cycle read/write strobe. Provides one packet of buffering in each direction.

Parameters:
- DATA_WIDTH, 64, packet/flit width on both network and PE sides.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- addr  input  2  PE register select: 00 rx buffer, 01 rx status, 10 tx buffer, 11 tx status
- d_in  input  DATA_WIDTH  PE write data
- d_out  output  DATA_WIDTH  PE read data (registered)
- nic_en  input  1  PE access strobe
- nic_wr_en  input  1  1 = write, 0 = read (only when nic_en=1)
- net_so  output  1  send to router; connects to router pesi
- net_ro  input  1  router ready; connects from router pero
- net_do  output  DATA_WIDTH  packet to router; connects to router pedi
- net_si  input  1  router sends; connects from router peso
- net_ri  output  1  NIC ready to accept; connects to router peri
- net_di  input  DATA_WIDTH  packet from router; connects from router pedo

Behaviour:
- Reset (async, reset_n=0) forces the following to 0: d_out, net_so, net_do, net_ri, both buffers, tx_full, rx_full. Outputs are held at 0 until reset_n deasserts. Reset mid-transfer discards any buffered packet.
- TX channel state machine: TX_EMPTY -> TX_FULL -> TX_EMPTY.
  - TX_EMPTY: PE write to addr 10 loads the tx buffer from d_in and sets tx_full on the same edge.
  - TX_FULL: PE writes to addr 10 are ignored (no overwrite).
  - TX_FULL with net_ro=1 at a rising edge: net_so=1 and net_do=buffer for exactly the next cycle. tx_full clears on that same edge.
  - net_so is never high for two consecutive cycles. net_do returns to 0 when net_so=0.
  - Minimum write-to-net_so latency is 2 cycles: the write edge, then the edge that samples net_ro.
- RX channel state machine: RX_EMPTY -> RX_FULL -> RX_EMPTY.
  - net_ri = ~rx_full. It is registered, so it updates the cycle after rx_full changes.
  - net_si=1 while net_ri=1: capture net_di into the rx buffer and set rx_full.
  - net_si=1 while net_ri=0 is a router protocol error: the packet is dropped and the buffer is unchanged.
  - A PE read of addr 00 returns the buffer on d_out the next cycle and clears rx_full on the same edge.
  - A PE read of addr 00 while rx is empty returns stale buffer contents and leaves rx_full at 0.
- Register reads (nic_en=1, nic_wr_en=0) are registered, with 1-cycle latency.
  - addr 01 returns {63'b0, rx_full}.
  - addr 11 returns {63'b0, tx_full}.
  - addr 10 returns 0.
  - With no read active, d_out holds its last value.
- Writes to addr 00, 01 and 11 are ignored.
- Simultaneous events:
  - PE write to addr 10 on the same edge tx drains: the write is ignored, because tx_full was 1 when sampled.
  - PE read of addr 00 on the same edge net_si arrives while rx is full: the read clears the buffer and net_si is dropped, because net_ri was 0.
- The TX and RX channels are fully independent and may be active in the same cycle.

Test Plan:
- Reset: assert reset_n=0 mid-run with tx_full=1 -> net_so, net_ri, d_out become 0 immediately, with no clock edge needed. After release: net_ri=1 and status reads return 0.
- TX basic: with net_ro=1, write 64'hDEAD_BEEF_0000_0001 to addr 10 -> net_so=1 with that data for exactly one cycle, 2 cycles after the write. A following addr 11 read returns 0.
- TX backpressure: net_ro=0 and write A, then write B -> tx status reads 1 and net_so stays 0. Raise net_ro -> A is sent once; B is never sent.
- RX basic: drive net_si=1 with net_di=64'h1234 -> net_ri drops the next cycle and an addr 01 read returns 1. An addr 00 read returns 64'h1234 after 1 cycle, then net_ri returns to 1.
- RX overrun: while rx is full, drive net_si=1 with 64'h5555 -> an addr 00 read still returns the first packet.
- Concurrent: tx send and rx capture in the same cycle -> both complete correctly and the status bits are independent.

Source files
------------

// File: rtl/pe_nic.sv
// NIC between one processing element and the PE port of a mesh router.
// One packet of buffering per direction; the PE sees a 4-entry register map.
module pe_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nic_en,
    input  logic                  nic_wr_en,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    typedef enum logic {TX_EMPTY = 1'b0, TX_FULL = 1'b1} tx_state_t;
    typedef enum logic {RX_EMPTY = 1'b0, RX_FULL = 1'b1} rx_state_t;

    localparam logic [1:0] ADDR_RX_BUF  = 2'b00;
    localparam logic [1:0] ADDR_RX_STAT = 2'b01;
    localparam logic [1:0] ADDR_TX_BUF  = 2'b10;
    localparam logic [1:0] ADDR_TX_STAT = 2'b11;

    tx_state_t             tx_state;
    rx_state_t             rx_state;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] rx_buf;

    logic tx_full;
    logic rx_full;
    logic pe_rd;
    logic tx_write;
    logic rx_read;
    logic rx_capture;

    assign tx_full    = (tx_state == TX_FULL);
    assign rx_full    = (rx_state == RX_FULL);
    assign pe_rd      = nic_en & ~nic_wr_en;
    assign tx_write   = nic_en & nic_wr_en & (addr == ADDR_TX_BUF);
    assign rx_read    = pe_rd & (addr == ADDR_RX_BUF);
    // Capture is gated by the registered ready the router actually saw.
    assign rx_capture = net_si & net_ri;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_EMPTY;
            rx_state <= RX_EMPTY;
            tx_buf   <= '0;
            rx_buf   <= '0;
            d_out    <= '0;
            net_so   <= 1'b0;
            net_do   <= '0;
            net_ri   <= 1'b0;
        end else begin
            // Send pulse is one cycle wide; the drain empties the buffer,
            // so a back-to-back pulse is impossible.
            net_so <= 1'b0;
            net_do <= '0;
            case (tx_state)
                TX_EMPTY: begin
                    if (tx_write) begin
                        tx_buf   <= d_in;
                        tx_state <= TX_FULL;
                    end
                end
                TX_FULL: begin
                    if (net_ro) begin
                        net_so   <= 1'b1;
                        net_do   <= tx_buf;
                        tx_state <= TX_EMPTY;
                    end
                end
                default: tx_state <= TX_EMPTY;
            endcase

            net_ri <= ~rx_full;
            if (rx_read) begin
                rx_state <= RX_EMPTY;
            end
            if (rx_capture) begin
                rx_buf   <= net_di;
                rx_state <= RX_FULL;
            end

            if (pe_rd) begin
                case (addr)
                    ADDR_RX_BUF:  d_out <= rx_buf;
                    ADDR_RX_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, rx_full};
                    ADDR_TX_BUF:  d_out <= '0;
                    ADDR_TX_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, tx_full};
                    default:      d_out <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_nic.sv
// Directed bench for pe_nic; register reads are checked through a scoreboard queue.
module tb_pe_nic;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    addr = 2'b00;
    logic [DW-1:0] d_in = '0;
    logic [DW-1:0] d_out;
    logic          nic_en = 1'b0;
    logic          nic_wr_en = 1'b0;
    logic          net_so;
    logic          net_ro = 1'b0;
    logic [DW-1:0] net_do;
    logic          net_si = 1'b0;
    logic          net_ri;
    logic [DW-1:0] net_di = '0;

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    pe_nic #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nic_en(nic_en), .nic_wr_en(nic_wr_en), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] d);
        addr = a; d_in = d; nic_en = 1'b1; nic_wr_en = 1'b1;
        tick();
        nic_en = 1'b0; nic_wr_en = 1'b0;
    endtask

    task automatic pe_read(input string tag, input logic [1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] e;
        addr = a; nic_en = 1'b1; nic_wr_en = 1'b0;
        exp_q.push_back(exp);
        tick();
        nic_en = 1'b0;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, d_out, e);
        end
    endtask

    localparam logic [DW-1:0] PKT_T  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [DW-1:0] PKT_A  = 64'hAAAA_0000_0000_000A;
    localparam logic [DW-1:0] PKT_B  = 64'hBBBB_0000_0000_000B;
    localparam logic [DW-1:0] PKT_C  = 64'hCCCC_1111_2222_3333;
    localparam logic [DW-1:0] PKT_D  = 64'h0D0D_0D0D_0D0D_0D0D;
    localparam logic [DW-1:0] PKT_E  = 64'hEEEE_EEEE_0000_0000;
    localparam logic [DW-1:0] PKT_F  = 64'hFFFF_0000_FFFF_0000;
    localparam logic [DW-1:0] PKT_G  = 64'h6666_7777_8888_9999;

    initial begin
        // Reset from power-up
        #1 reset_n = 1'b0;
        #1;
        check("reset_net_so", {63'b0, net_so}, 64'd0);
        check("reset_net_ri", {63'b0, net_ri}, 64'd0);
        check("reset_d_out", d_out, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_net_ri", {63'b0, net_ri}, 64'd1);
        pe_read("post_reset_rx_stat", 2'b01, 64'd0);
        pe_read("post_reset_tx_stat", 2'b11, 64'd0);
        pe_read("tx_buf_reads_zero", 2'b10, 64'd0);

        // TX basic
        net_ro = 1'b1;
        pe_write(2'b10, PKT_T);
        check("txb_so_after_write", {63'b0, net_so}, 64'd0);
        tick();
        check("txb_so_pulse", {63'b0, net_so}, 64'd1);
        check("txb_do", net_do, PKT_T);
        tick();
        check("txb_so_low", {63'b0, net_so}, 64'd0);
        check("txb_do_zero", net_do, 64'd0);
        pe_read("txb_tx_stat", 2'b11, 64'd0);

        // TX backpressure: second write must not overwrite the first
        net_ro = 1'b0;
        pe_write(2'b10, PKT_A);
        pe_write(2'b10, PKT_B);
        check("bp_so_held", {63'b0, net_so}, 64'd0);
        pe_read("bp_tx_stat", 2'b11, 64'd1);
        net_ro = 1'b1;
        tick();
        check("bp_so_pulse", {63'b0, net_so}, 64'd1);
        check("bp_do_a", net_do, PKT_A);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_b_never_sent", {63'b0, net_so}, 64'd0);
        end
        pe_read("bp_tx_stat_empty", 2'b11, 64'd0);

        // RX basic
        net_ro = 1'b0;
        net_si = 1'b1; net_di = 64'h1234;
        tick();
        net_si = 1'b0; net_di = '0;
        check("rx_ri_still_high", {63'b0, net_ri}, 64'd1);
        tick();
        check("rx_ri_drop", {63'b0, net_ri}, 64'd0);
        pe_read("rx_stat_full", 2'b01, 64'd1);

        // RX overrun: packet dropped while not ready
        net_si = 1'b1; net_di = 64'h5555;
        tick();
        net_si = 1'b0; net_di = '0;
        pe_read("rx_overrun_keeps_first", 2'b00, 64'h1234);
        tick();
        check("rx_ri_return", {63'b0, net_ri}, 64'd1);
        pe_read("rx_stat_empty", 2'b01, 64'd0);
        pe_read("rx_stale_read", 2'b00, 64'h1234);
        pe_read("rx_stat_stays_empty", 2'b01, 64'd0);

        // Concurrent send and capture
        net_ro = 1'b1;
        pe_write(2'b10, PKT_C);
        net_si = 1'b1; net_di = PKT_D;
        tick();
        net_si = 1'b0; net_di = '0;
        check("conc_so", {63'b0, net_so}, 64'd1);
        check("conc_do", net_do, PKT_C);
        tick();
        pe_read("conc_rx_stat", 2'b01, 64'd1);
        pe_read("conc_tx_stat", 2'b11, 64'd0);
        pe_read("conc_rx_data", 2'b00, PKT_D);

        // Write on the draining edge is ignored
        pe_write(2'b10, PKT_E);
        pe_write(2'b10, PKT_F);
        check("drain_so", {63'b0, net_so}, 64'd1);
        check("drain_do_e", net_do, PKT_E);
        tick();
        check("drain_so_low", {63'b0, net_so}, 64'd0);
        pe_read("drain_tx_stat", 2'b11, 64'd0);
        check("drain_f_not_sent", {63'b0, net_so}, 64'd0);

        // Asynchronous reset with a packet held in tx
        net_ro = 1'b0;
        pe_write(2'b10, PKT_G);
        pe_read("mid_tx_stat", 2'b11, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_d_out", d_out, 64'd0);
        check("async_net_ri", {63'b0, net_ri}, 64'd0);
        check("async_net_so", {63'b0, net_so}, 64'd0);
        tick();
        reset_n = 1'b1;
        net_ro = 1'b1;
        tick();
        check("rel_net_ri", {63'b0, net_ri}, 64'd1);
        check("rel_g_discarded", {63'b0, net_so}, 64'd0);
        pe_read("rel_tx_stat", 2'b11, 64'd0);
        check("rel_g_discarded2", {63'b0, net_so}, 64'd0);
        pe_read("rel_rx_stat", 2'b01, 64'd0);

        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
